// File: rtl/fifo_drain_if.sv
// Bundles the FIFO read port and the output valid/ready stream of fifo_drain.
interface fifo_drain_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  fifo_rd;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  // The drain: pops the FIFO and drives the stream.
  modport master (
    output fifo_rd, m_data, m_valid,
    input  fifo_empty, fifo_dout, m_ready
  );

  // The FIFO plus the downstream consumer.
  modport slave (
    input  fifo_rd, m_data, m_valid,
    output fifo_empty, fifo_dout, m_ready
  );
endinterface

// File: rtl/fifo_drain.sv
// FIFO read-side master: pops the FIFO, buffers up to two words and presents
// them in order on a valid/ready stream while counting delivered words.
//
// state | meaning
// IDLE  | no reads issued, busy=0
// RUN   | reads issued while buffer space is uncommitted
// DRAIN | no new reads; in-flight and buffered words still delivered
module fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drained_cnt,
  fifo_drain_if.master         bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  fifo_rd_q, fifo_rd_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  pop;
  logic [2:0]            committed;
  logic [1:0]            occ_after_pop;

  // Issue decision, buffer shift/capture and delivered-word counter.
  always_comb begin
    pop           = (occ_q != 2'd0) & bus.m_ready;
    committed     = {1'b0, occ_q} + {2'b00, fifo_rd_q} - {2'b00, pop};
    fifo_rd_d     = (state_q == RUN) & !bus.fifo_empty & !flush & (committed < 3'd2);
    buf_d         = buf_q;
    occ_after_pop = occ_q - {1'b0, pop};
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    // The word read last cycle lands at the first free slot after the pop.
    if (fifo_rd_q) begin
      if (occ_after_pop == 2'd0) begin
        buf_d[0] = bus.fifo_dout;
      end else begin
        buf_d[1] = bus.fifo_dout;
      end
    end
    occ_d = occ_after_pop + {1'b0, fifo_rd_q};
    if (flush) begin
      occ_d = 2'd0;
    end
    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
  end

  // Next-state logic; flush overrides the normal transitions.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = enable ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = RUN;
        RUN:     if (!enable) state_d = DRAIN;
        DRAIN: begin
          if (enable) begin
            state_d = RUN;
          end else if ((occ_q == 2'd0) && !fifo_rd_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, buffer and counter registers; reset drops any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      occ_q     <= 2'd0;
      fifo_rd_q <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      fifo_rd_q <= fifo_rd_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.fifo_rd = fifo_rd_q;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = buf_q[0];
  assign busy        = (state_q != IDLE);
  assign drained_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a 64-entry FIFO model and a stream sink.
module tb_fifo_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       flush;
  logic       busy;
  logic [3:0] drained_cnt;

  fifo_drain_if #(.DATA_WIDTH(8)) bus ();

  fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .flush       (flush),
    .busy        (busy),
    .drained_cnt (drained_cnt),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: head word is shown on fifo_dout and popped on the edge that
  // sees fifo_rd=1; empty already accounts for a pop that is under way.
  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  bit         fifo_clr = 1'b0;
  int         underflow = 0;

  assign bus.fifo_dout  = mem[rd_ptr[5:0]];
  assign bus.fifo_empty = ((wr_ptr - rd_ptr) <= (bus.fifo_rd ? 1 : 0));

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] got [$];
  logic [7:0] exp [$];
  int         rd_pulses;
  int         prev_committed;
  int         max_out;
  int         bad_issue;

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp.push_back(w);
  endtask

  // One clock: sample outputs mid-cycle, then return 1 time unit after the edge.
  task automatic step();
    @(negedge clk);
    if (bus.fifo_rd) begin
      rd_pulses++;
      if (prev_committed >= 2) bad_issue++;
    end
    if (rd_pulses - got.size() > max_out) max_out = rd_pulses - got.size();
    if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
    prev_committed = rd_pulses - got.size();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
    fifo_clr = 1'b1;
    step(); step();
    fifo_clr = 1'b0;
    got.delete(); exp.delete();
    rd_pulses = 0; prev_committed = 0; max_out = 0; bad_issue = 0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
    #1;
    step();
    n_cmp++; if (bus.fifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_rd: got %b want 0", bus.fifo_rd); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 8'h00) begin n_bad++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (drained_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", drained_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 15; i++) push(8'(i * 37 + 5));
    enable = 1'b1; bus.m_ready = 1'b1;
    for (int k = 0; k < 200 && got.size() < 15; k++) step();
    n_cmp++; if (got.size() != 15) begin n_bad++; $display("FAIL basic_count: got %0d want 15", got.size()); end
    for (int i = 0; i < 15 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL basic_order[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (drained_cnt !== 4'd15) begin n_bad++; $display("FAIL basic_cnt: got %0d want 15", drained_cnt); end
    n_cmp++; if (rd_pulses != 15) begin n_bad++; $display("FAIL basic_rd_pulses: got %0d want 15", rd_pulses); end
    enable = 1'b0;
    for (int k = 0; k < 20 && busy; k++) step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: busy %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; bus.m_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    step();
    n_cmp++; if (bus.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL bp_latency_rd: got %b want 1", bus.fifo_rd); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_latency_early_valid: got %b want 0", bus.m_valid); end
    step();
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_latency_valid: got %b want 1", bus.m_valid); end
    for (int k = 0; k < 6; k++) step();
    n_cmp++; if (rd_pulses != 2) begin n_bad++; $display("FAIL bp_rd_pulses: got %0d want 2", rd_pulses); end
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 1", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 8'hC0) begin n_bad++; $display("FAIL bp_hold_data: got %h want c0", bus.m_data); end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 60 && got.size() < 5; k++) step();
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (got.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (drained_cnt !== 4'd5) begin n_bad++; $display("FAIL bp_cnt: got %0d want 5", drained_cnt); end
  endtask

  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 10; i++) push(8'h51 ^ 8'(i * 11));
    enable = 1'b1; bus.m_ready = 1'b1;
    for (int k = 0; k < 200 && got.size() < 10; k++) begin
      step();
      bus.m_ready = ~bus.m_ready;
    end
    n_cmp++; if (got.size() != 10) begin n_bad++; $display("FAIL toggle_count: got %0d want 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL toggle_order[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (bad_issue != 0) begin n_bad++; $display("FAIL toggle_over_issue: got %0d want 0", bad_issue); end
    n_cmp++; if (max_out > 2) begin n_bad++; $display("FAIL toggle_occupancy: got %0d want <=2", max_out); end
    n_cmp++; if (drained_cnt !== 4'd10) begin n_bad++; $display("FAIL toggle_cnt: got %0d want 10", drained_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    enable = 1'b1; bus.m_ready = 1'b0;
    step(); step(); step();
    n_cmp++; if ({bus.m_valid, bus.fifo_rd} !== 2'b11) begin n_bad++; $display("FAIL flush_setup: got %b want 11", {bus.m_valid, bus.fifo_rd}); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", bus.m_valid); end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 60 && got.size() < 4; k++) step();
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL flush_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i + 2]) begin n_bad++; $display("FAIL flush_order[%0d]: got %h want %h", i, got[i], exp[i + 2]); end
    end
    n_cmp++; if (drained_cnt !== 4'd4) begin n_bad++; $display("FAIL flush_cnt: got %0d want 4", drained_cnt); end
  endtask

  task automatic test_disable_inflight();
    do_reset();
    for (int i = 0; i < 3; i++) push(8'h90 + 8'(i));
    enable = 1'b1; bus.m_ready = 1'b1;
    step();
    enable = 1'b0;
    step();
    n_cmp++; if (bus.fifo_rd !== 1'b1) begin n_bad++; $display("FAIL dis_rd: got %b want 1", bus.fifo_rd); end
    step();
    n_cmp++; if ({bus.m_valid, bus.m_data} !== {1'b1, 8'h90}) begin n_bad++; $display("FAIL dis_word: got %b/%h want 1/90", bus.m_valid, bus.m_data); end
    step();
    n_cmp++; if ({bus.m_valid, busy, drained_cnt} !== {1'b0, 1'b1, 4'd1}) begin n_bad++; $display("FAIL dis_after_pop: got v%b b%b c%0d want v0 b1 c1", bus.m_valid, busy, drained_cnt); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dis_busy_fall: got %b want 0", busy); end
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if (rd_pulses != 1) begin n_bad++; $display("FAIL dis_rd_pulses: got %0d want 1", rd_pulses); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
    enable = 1'b1; bus.m_ready = 1'b1;
    for (int k = 0; k < 60 && got.size() < 3; k++) step();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_cmp++; if ({bus.m_valid, busy, drained_cnt} !== {1'b1, 1'b1, 4'd3}) begin n_bad++; $display("FAIL arst_setup: got v%b b%b c%0d want v1 b1 c3", bus.m_valid, busy, drained_cnt); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.fifo_rd, bus.m_valid, busy} !== 3'b000) begin n_bad++; $display("FAIL arst_outputs: got %b want 000", {bus.fifo_rd, bus.m_valid, busy}); end
    n_cmp++; if (drained_cnt !== 4'd0) begin n_bad++; $display("FAIL arst_cnt: got %0d want 0", drained_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(255 - i * 13));
    enable = 1'b1; bus.m_ready = 1'b1;
    for (int k = 0; k < 200 && got.size() < 17; k++) step();
    for (int k = 0; k < 3; k++) step();
    n_cmp++; if (got.size() != 17) begin n_bad++; $display("FAIL wrap_count: got %0d want 17", got.size()); end
    for (int i = 0; i < 17 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (drained_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 1", drained_cnt); end
    n_cmp++; if (underflow != 0) begin n_bad++; $display("FAIL no_underflow: got %0d want 0", underflow); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
    rd_pulses = 0; prev_committed = 0; max_out = 0; bad_issue = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_flush();
    test_disable_inflight();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
